// File: rtl/dataout_uart_pkg.sv
// Shared types and constants for the dataout_uart serial output stage.
// DATAOUT_UART_PARITY_EN selects 8E1 framing instead of 8N1.
package dataout_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam int   UART_DATA_BITS  = 8;

  function automatic int frame_bits();
`ifdef DATAOUT_UART_PARITY_EN
    return 11;
`else
    return 10;
`endif
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO; pointers carry an extra wrap bit so full and
// empty are distinct. A push while full is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr, r_rptr;
  logic             w_do_push, w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_count   = r_wptr - r_rptr;
  assign o_data    = r_mem[r_rptr[AW-1:0]];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/dataout_uart.sv
// Captures every change of the core's output byte into a FIFO and shifts
// queued bytes out as UART frames. DATAOUT_UART_PARITY_EN adds an even parity bit.
module dataout_uart
  import dataout_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    data_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount_o,
  output logic                          overflow_o
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_t   r_state;
  logic [7:0]  r_prev, r_shift;
  logic [BW-1:0] r_baud;
  logic [2:0]  r_bit;
  logic        r_tx, r_busy, r_ovf;
`ifdef DATAOUT_UART_PARITY_EN
  logic        r_parity;
`endif

  logic        w_push, w_pop, w_full, w_empty, w_last;
  logic [7:0]  w_fifo_data;

  assign w_push = (data_i != r_prev);
  assign w_last = (r_baud == BW'(CLKS_PER_BIT - 1));
  assign w_pop  = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_last));

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (data_i),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifoCount_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_prev  <= 8'h00;
      r_shift <= 8'h00;
      r_baud  <= '0;
      r_bit   <= '0;
      r_tx    <= UART_IDLE_LEVEL;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
`ifdef DATAOUT_UART_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_prev <= data_i;
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      r_baud <= w_last ? '0 : r_baud + 1'b1;
      case (r_state)
        IDLE: begin
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= w_fifo_data;
            r_bit   <= '0;
            r_state <= START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
`ifdef DATAOUT_UART_PARITY_EN
            r_parity <= ^w_fifo_data;
`endif
          end
        end
        START: if (w_last) begin
          r_state <= DATA;
          r_tx    <= r_shift[0];
        end
        DATA: if (w_last) begin
          if (r_bit == 3'(UART_DATA_BITS - 1)) begin
`ifdef DATAOUT_UART_PARITY_EN
            r_state <= PARITY;
            r_tx    <= r_parity;
`else
            r_state <= STOP;
            r_tx    <= UART_IDLE_LEVEL;
`endif
          end else begin
            r_shift <= r_shift >> 1;
            r_tx    <= r_shift[1];
            r_bit   <= r_bit + 1'b1;
          end
        end
`ifdef DATAOUT_UART_PARITY_EN
        PARITY: if (w_last) begin
          r_state <= STOP;
          r_tx    <= UART_IDLE_LEVEL;
        end
`endif
        STOP: if (w_last) begin
          // Chain straight into the next start bit when more bytes wait.
          if (w_pop) begin
            r_shift <= w_fifo_data;
            r_bit   <= '0;
            r_state <= START;
            r_tx    <= 1'b0;
`ifdef DATAOUT_UART_PARITY_EN
            r_parity <= ^w_fifo_data;
`endif
          end else begin
            r_state <= IDLE;
            r_tx    <= UART_IDLE_LEVEL;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= UART_IDLE_LEVEL;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_o       = r_tx;
  assign busy_o     = r_busy;
  assign overflow_o = r_ovf;
endmodule

// File: tb/tb_dataout_uart.sv
// Bench for dataout_uart: frame-timeline model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_dataout_uart;
  localparam int C = 4;
  localparam int D = 4;
`ifdef DATAOUT_UART_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       tx, busy, ovf;
  logic [2:0] cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  dataout_uart #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst), .data_i(data),
    .tx_o(tx), .busy_o(busy), .fifoCount_o(cnt), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  // Model: queue of waiting bytes and a position t within the current frame.
  logic [7:0] q[$];
  logic [7:0] popped[$];
  logic [7:0] m_prev = 8'h00;
  logic [7:0] cur = 8'h00;
  int         t = -1;
  bit         m_ovf = 0;

  task automatic model_step();
    bit pop;
    logic [7:0] d;
    d = data;
    if (rst) begin
      q.delete(); t = -1; m_prev = 8'h00; m_ovf = 0;
      return;
    end
    pop = (q.size() > 0) && (t < 0 || t == FL*C - 1);
    if (t >= 0) t++;
    if (t == FL*C) t = -1;
    if (pop) begin
      cur = q.pop_front();
      popped.push_back(cur);
      t = 0;
    end
    if (d != m_prev) begin
      if (q.size() < D) q.push_back(d);
      else m_ovf = 1;
    end
    m_prev = d;
  endtask

  function automatic logic exp_tx();
    int b;
    if (t < 0) return 1'b1;
    b = t / C;
    if (b == 0) return 1'b0;
    if (b <= 8) return cur[b-1];
`ifdef DATAOUT_UART_PARITY_EN
    if (b == 9) return ^cur;
`endif
    return 1'b1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("model_tx", int'(tx), int'(exp_tx()));
      chk("model_busy", int'(busy), (t >= 0) ? 1 : 0);
      chk("model_count", int'(cnt), q.size());
      chk("model_overflow", int'(ovf), int'(m_ovf));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  logic [8:0] pat_a5 = 9'b10100101_0;
  logic [7:0] exp_bytes[$];

  initial begin
    rst = 1'b1; data = 8'h00;
    step(3);
    rst = 1'b0; chk_en = 1;
    chk("rst_tx", tx, 1); chk("rst_busy", busy, 0);
    chk("rst_count", cnt, 0); chk("rst_ovf", ovf, 0);

    step(100);
    chk("idle_tx", tx, 1); chk("idle_count", cnt, 0); chk("idle_busy", busy, 0);

    // Single byte 0xA5: start bit two edges after the change.
    data = 8'hA5;
    step(1);
    chk("a5_push_count", cnt, 1); chk("a5_tx_before_start", tx, 1);
    step(1);
    chk("a5_start_tx", tx, 0); chk("a5_busy", busy, 1); chk("a5_popped_count", cnt, 0);
    step(2);
    chk("a5_bit0", tx, int'(pat_a5[0]));
    for (int b = 1; b <= 8; b++) begin
      step(4);
      chk("a5_bit", tx, int'(pat_a5[b]));
    end
    step(FL*C - 35);
    chk("a5_busy_last", busy, 1);
    step(1);
    chk("a5_busy_done", busy, 0); chk("a5_tx_done", tx, 1);

    // Back-to-back frames.
    data = 8'h01; step(1);
    data = 8'h02; step(1);
    data = 8'h03; step(1);
    chk("b2b_peak_count", cnt, 2);
    step(3*FL*C + 10);
    chk("b2b_idle", busy, 0);

    // Overflow: six changes with TX idle.
    for (int i = 0; i < 6; i++) begin
      data = 8'h11 + 8'(i);
      step(1);
    end
    chk("ovf_full_count", cnt, 4); chk("ovf_set", ovf, 1);
    step(5*FL*C + 20);
    chk("ovf_sticky", ovf, 1); chk("ovf_drained", cnt, 0);

    // Reset while bit 3 of 0xFF is on the line.
    data = 8'hFF;
    step(2);
    step(17);
    chk("ff_busy_mid", busy, 1);
    rst = 1'b1; data = 8'h00;
    step(1);
    chk("midrst_tx", tx, 1); chk("midrst_count", cnt, 0);
    chk("midrst_ovf", ovf, 0); chk("midrst_busy", busy, 0);
    rst = 1'b0;
    step(2);
    data = 8'h3C;
    step(2);
    chk("3c_start", tx, 0);
    step(FL*C + 10);
    chk("3c_done", busy, 0);

`ifdef DATAOUT_UART_PARITY_EN
    data = 8'h07;
    step(2);
    step(38);
    chk("par07_bit", tx, 1);
    step(50);
    data = 8'h03;
    step(2);
    step(38);
    chk("par03_bit", tx, 0);
    step(50);
`endif

    exp_bytes = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'hFF, 8'h3C};
`ifdef DATAOUT_UART_PARITY_EN
    exp_bytes.push_back(8'h07);
    exp_bytes.push_back(8'h03);
`endif
    chk("sent_count", popped.size(), exp_bytes.size());
    for (int i = 0; i < exp_bytes.size() && i < popped.size(); i++)
      chk("sent_byte", int'(popped[i]), int'(exp_bytes[i]));

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
